zld_xc: RTL and testbench
=========================

// Module: zld_xc
// PURPOSE
// - Zero run-length decoder: inverse of the ZLE encoder stream format, with no EOS cases.
// - Consumes 4-bit tokens on stream i and regenerates the original 3-bit sample stream on o.
// - Token format:
//   - In S_LIT, a non-zero token is a literal.
//   - In S_LIT, the zero token is a run marker.
//   - The token after a marker is a count c, expanding to c+1 zero samples (1..16).
// - Sits downstream of zle_xc; loopback zle_xc -> zld_xc must be the identity.
// PARAMETERS
// - D_W    3  sample width; token width is D_W+1
// - CNT_W  4  run-count width; CNT_W <= D_W+1; max run = 2**CNT_W
// PORTS
// - clock  in   1        single clock, rising edge
// - reset  in   1        asynchronous, active-low reset
// - i_d    in   D_W+1    input token
// - i_v    in   1        input token valid
// - i_b    out  1        input backpressure; token accepted when i_v && !i_b
// - o_d    out  D_W      output sample (registered)
// - o_v    out  1        output valid (registered)
// - o_b    in   1        output backpressure; sample consumed when o_v && !o_b
// - o_err  out  1        sticky format error (only with ZLD_ERR_EN)
// BEHAVIOUR
// - Reset (reset==0, async): state=S_LIT, o_v=0, o_d=0, rem=0, o_err=0.
//   - i_b=1 while reset is low.
//   - Reset mid-run discards the in-flight token, the remaining run and the held sample.
// - slot_free = !o_v || !o_b (output register empty or being drained this cycle).
// - i_b = !slot_free || (state==S_RUN). The input is never accepted during a run expansion.
// - States:
//   - S_LIT, accept token t:
//     - t[D_W-1:0]!=0: load o_d=t[D_W-1:0], o_v=1; stay in S_LIT.
//     - t[D_W-1:0]==0: marker; no output; go to S_CNT.
//   - S_CNT, accept count c=t[CNT_W-1:0]:
//     - Load o_d=0, o_v=1 (first zero).
//     - c==0: go to S_LIT.
//     - c!=0: rem=c, go to S_RUN.
//   - S_RUN, when slot_free:
//     - Load o_d=0, o_v=1, rem=rem-1.
//     - If rem==1, go to S_LIT.
// - Output hold: when slot_free==0, o_d/o_v are held unchanged and no state advances.
// - If slot_free && no load this cycle: o_v <= 0.
// - Latency: accepted literal or count appears on o the next cycle. Marker tokens produce no output.
// - Throughput: 1 sample/cycle with o_b=0, including back-to-back literals and runs.
// - A 16-zero run (c=15) occupies 16 consecutive output cycles. The next token is accepted in the cycle the last zero is loaded + 1.
// - rem is CNT_W bits and never wraps: decrement happens only in S_RUN with rem>=1.
// - Tokens with bit D_W set in S_LIT: the low bits decide literal vs marker. Bit D_W is otherwise ignored.
// - In S_CNT, bits above CNT_W-1 are ignored.
// - i_d is don't-care when i_v==0. No state change without an accept, or without slot_free in S_RUN.
// CONFIGURATION
// - ZLD_ERR_EN defined:
//   - o_err port present.
//   - Set to 1 on accept in S_LIT of a token with bit D_W set.
//   - Set to 1 on accept in S_CNT of a token with any bit above CNT_W-1 set.
//   - Sticky until reset.
//   - Decoding behaviour is unchanged.
// - ZLD_ERR_EN undefined: no o_err port, no error logic. All other behaviour is identical.
// TESTING
// - Literals: tokens 3,5,7 with o_b=0 -> o_d=3,5,7 on consecutive cycles, 1-cycle latency, i_b=0 throughout.
// - Short run: tokens 0,0 (marker, c=0) then 4 -> o_d=0 (one cycle) then 4.
//   - The marker cycle produces o_v=0.
// - Max run: tokens 0,15,2 -> sixteen o_d=0 then 2.
//   - i_b=1 for exactly the 15 S_RUN cycles; rem reaches 0 with no wrap.
// - Backpressure: o_b=1 for 5 cycles mid-run of c=6 -> o_d/o_v held, rem frozen, i_b=1.
//   - Total zeros out = 7 after o_b drops.
// - Async reset: assert reset low during S_RUN with rem=9 -> o_v=0 and state S_LIT immediately.
//   - After release, token 6 -> o_d=6 and no stray zeros.
// - ZLD_ERR_EN: token 4'b1011 in S_LIT -> o_d=3 and o_err=1 next cycle; o_err stays 1 until reset.
//   - Without the macro, the same stimulus gives o_d=3.

Source files
------------

// File: rtl/zld_xc.sv
// Zero run-length decoder: expands (marker, count) token pairs into runs of zero samples.
// Optional sticky format-error flag o_err is built when ZLD_ERR_EN is defined.
module zld_xc #(
    parameter int D_W   = 3,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [D_W:0]     i_d,
    input  logic             i_v,
    output logic             i_b,
    output logic [D_W-1:0]   o_d,
    output logic             o_v,
    input  logic             o_b,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_rem
`ifdef ZLD_ERR_EN
    ,
    output logic             o_err
`endif
);

    typedef enum logic [1:0] {
        S_LIT = 2'd0,
        S_CNT = 2'd1,
        S_RUN = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] rem;
    logic             slot_free;
    logic             accept;
    logic [CNT_W-1:0] count;

    // Handshake: a token moves when i_v && !i_b; a sample moves when o_v && !o_b.
    // The output register accepts a new sample only when empty or being drained.
    assign slot_free = !o_v || !o_b;
    assign i_b       = !reset || !slot_free || (state == S_RUN);
    assign accept    = i_v && !i_b;
    assign count     = i_d[CNT_W-1:0];

    assign dbg_state = state;
    assign dbg_rem   = rem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_LIT;
            o_v   <= 1'b0;
            o_d   <= '0;
            rem   <= '0;
        end else if (slot_free) begin
            o_v <= 1'b0;
            unique case (state)
                S_LIT: begin
                    if (accept) begin
                        if (i_d[D_W-1:0] != '0) begin
                            o_d <= i_d[D_W-1:0];
                            o_v <= 1'b1;
                        end else begin
                            state <= S_CNT;
                        end
                    end
                end
                S_CNT: begin
                    if (accept) begin
                        o_d <= '0;
                        o_v <= 1'b1;
                        if (count == '0) begin
                            state <= S_LIT;
                        end else begin
                            rem   <= count;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // rem counts zeros still to emit after the first; it is >= 1 here
                    o_d <= '0;
                    o_v <= 1'b1;
                    rem <= rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        state <= S_LIT;
                    end
                end
                default: state <= S_LIT;
            endcase
        end
    end

`ifdef ZLD_ERR_EN
    logic upper_set;
    assign upper_set = (i_d >> CNT_W) != '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_err <= 1'b0;
        end else if (accept) begin
            if ((state == S_LIT) && i_d[D_W]) begin
                o_err <= 1'b1;
            end
            if ((state == S_CNT) && upper_set) begin
                o_err <= 1'b1;
            end
        end
    end
`else
    logic unused_top_bit;
    assign unused_top_bit = i_d[D_W];
`endif

endmodule

// File: tb/tb_zld_xc.sv
// Bench for zld_xc: token-level decoding model with an expected-sample queue,
// directed scenarios with literal expectations, then randomized traffic.
module tb_zld_xc;

    localparam int D_W   = 3;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [D_W:0]     i_d   = '0;
    logic             i_v   = 1'b0;
    logic             i_b;
    logic [D_W-1:0]   o_d;
    logic             o_v;
    logic             o_b   = 1'b0;
    logic [1:0]       dbg_state;
    logic [CNT_W-1:0] dbg_rem;
`ifdef ZLD_ERR_EN
    logic             o_err;
`endif

    zld_xc #(.D_W(D_W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .i_d       (i_d),
        .i_v       (i_v),
        .i_b       (i_b),
        .o_d       (o_d),
        .o_v       (o_v),
        .o_b       (o_b),
        .dbg_state (dbg_state),
        .dbg_rem   (dbg_rem)
`ifdef ZLD_ERR_EN
        ,
        .o_err     (o_err)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: decode accepted tokens straight into the samples they stand for.
    logic [D_W-1:0] exp_q[$];
    bit             expect_cnt = 0;
    int             pending    = 0;
    bit             err_model  = 0;
    bit             hold_prev  = 0;
    logic [D_W-1:0] hold_d     = '0;

    task automatic model_accept(input logic [D_W:0] t);
        int c;
        if (!expect_cnt) begin
            if (t[D_W]) err_model = 1;
            if (t[D_W-1:0] != '0) exp_q.push_back(t[D_W-1:0]);
            else expect_cnt = 1;
        end else begin
            c = int'(t[CNT_W-1:0]);
            if ((t >> CNT_W) != '0) err_model = 1;
            for (int k = 0; k <= c; k++) exp_q.push_back('0);
            pending    = c;
            expect_cnt = 0;
        end
    endtask

    always @(negedge clock) begin : monitor
        logic slot_free;
        slot_free = !o_v || !o_b;
        if (!reset) begin
            exp_q.delete();
            expect_cnt = 0;
            pending    = 0;
            err_model  = 0;
            hold_prev  = 0;
            chk("ib_in_reset", i_b, 1);
            chk("ov_in_reset", o_v, 0);
        end else begin
            if (hold_prev) begin
                chk("hold_ov", o_v, 1);
                chk("hold_od", o_d, hold_d);
            end
            chk("ib_rule", i_b, (!slot_free || pending > 0));
`ifdef ZLD_ERR_EN
            chk("err_flag", o_err, err_model);
`endif
            if (o_v && !o_b) begin
                if (exp_q.size() == 0) chk("stray_out", o_v, 0);
                else chk("sample", o_d, exp_q.pop_front());
            end
            if (pending > 0 && slot_free) pending--;
            if (i_v && !i_b) model_accept(i_d);
            hold_prev = o_v && o_b;
            hold_d    = o_d;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [D_W:0] d);
        i_v = v;
        i_d = d;
    endtask

    task automatic look(input string name, input logic v, input logic [D_W-1:0] d);
        @(negedge clock);
        chk({name, "_v"}, o_v, v);
        if (v) chk({name, "_d"}, o_d, d);
    endtask

    initial begin
        int zeros, ibc, cons, r0;
        bit got2, acc, fin, found;
        logic [D_W:0] t;

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_ov", o_v, 0);
        chk("rst_od", o_d, 0);
        chk("rst_ib", i_b, 1);
        chk("rst_rem", dbg_rem, 0);
        @(posedge clock);
        #1 reset = 1'b1;

        // Literals 3,5,7 back to back
        drive(1, 3); @(negedge clock); chk("lit_ib0", i_b, 0); step();
        drive(1, 5); look("lit1", 1, 3); chk("lit_ib1", i_b, 0); step();
        drive(1, 7); look("lit2", 1, 5); chk("lit_ib2", i_b, 0); step();
        drive(0, 0); look("lit3", 1, 7); step();
        look("lit_idle", 0, 0); step();

        // Short run: marker, c=0, then literal 4
        drive(1, 0); look("sr_pre", 0, 0); step();
        drive(1, 0); look("sr_marker", 0, 0); step();
        drive(1, 4); look("sr_zero", 1, 0); chk("sr_ib", i_b, 0); step();
        drive(0, 0); look("sr_lit", 1, 4); step();
        look("sr_idle", 0, 0); step();

        // Max run: marker, c=15, then literal 2
        drive(1, 0); step();
        drive(1, 15); step();
        drive(1, 2);
        zeros = 0; ibc = 0; got2 = 0;
        for (int k = 0; k < 40 && !got2; k++) begin
            @(negedge clock);
            if (o_v && o_d == 0) zeros++;
            if (o_v && o_d == 2) got2 = 1;
            if (i_b) ibc++;
            acc = i_v && !i_b;
            step();
            if (acc) drive(0, 0);
        end
        chk("max_zeros", zeros, 16);
        chk("max_ib_cycles", ibc, 15);
        chk("max_lit_seen", got2, 1);
        chk("max_rem_end", dbg_rem, 0);
        look("max_idle", 0, 0); step();

        // Backpressure mid-run of c=6
        drive(1, 0); step();
        drive(1, 6); step();
        drive(0, 0);
        cons = 0;
        repeat (2) begin
            @(negedge clock);
            if (o_v && !o_b && o_d == 0) cons++;
            step();
        end
        o_b = 1'b1;
        @(negedge clock);
        r0 = int'(dbg_rem);
        chk("bp_rem_start", r0, 4);
        chk("bp_ov", o_v, 1);
        step();
        repeat (4) begin
            @(negedge clock);
            chk("bp_ib", i_b, 1);
            chk("bp_rem_frozen", dbg_rem, r0);
            chk("bp_ov_held", o_v, 1);
            step();
        end
        o_b = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (o_v && o_d == 0) cons++;
            fin = !o_v;
            step();
            if (fin) break;
        end
        chk("bp_total", cons, 7);

        // Async reset during a run with rem=9
        drive(1, 0); step();
        drive(1, 12); step();
        drive(0, 0);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (dbg_rem == 9) begin
                found = 1;
                break;
            end
            step();
        end
        chk("ar_found_rem9", found, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_ov", o_v, 0);
        chk("ar_ib", i_b, 1);
        chk("ar_rem", dbg_rem, 0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        drive(1, 6); @(negedge clock); chk("ar_ib_after", i_b, 0); step();
        drive(0, 0); look("ar_lit", 1, 6); step();
        look("ar_nostray", 0, 0); step();

        // Literal with the top bit set
        drive(1, 4'b1011); step();
        drive(0, 0); look("err_lit", 1, 3);
`ifdef ZLD_ERR_EN
        chk("err_set", o_err, 1);
`endif
        step();

        // Randomized traffic with one mid-stream reset
        for (int n = 0; n < 3000; n++) begin
            t = D_W'(0) == 0 ? (D_W + 1)'($urandom_range(0, 15)) : '0;
            if ($urandom_range(0, 2) == 0) t[D_W-1:0] = '0;
            i_v = ($urandom_range(0, 3) != 0);
            i_d = t;
            o_b = ($urandom_range(0, 3) == 0);
            if (n == 1500) reset = 1'b0;
            if (n == 1502) reset = 1'b1;
            step();
        end
        i_v = 1'b0;
        o_b = 1'b0;
        repeat (40) step();
        @(negedge clock);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_ov", o_v, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
